// File: rtl/ahb2apb_bridge.sv
// AHB-Lite to APB bridge, one transfer in flight; read done N+3, write N+4 with zero APB wait states.
// Stalls AHB via HREADYOUT while APB runs; define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
module ahb2apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 256
`endif
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t state, state_nxt;
  logic   take;
  logic   done;
  logic   abort;
  logic   unused_ok;

  // Size is not decoded: every APB access is a full word.
  assign unused_ok = ^{HSIZE, HTRANS[0]};

  assign take = HREADYOUT & HSEL & HTRANS[1] & HREADY;
  assign done = (state == ACCESS) & PREADY;

`ifdef APB_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                            tmo_cnt <= '0;
    else if (state == SETUP)                 tmo_cnt <= '0;
    else if ((state == ACCESS) && !PREADY)   tmo_cnt <= tmo_cnt + 16'd1;
  end

  // PREADY on the terminal-count cycle still completes normally.
  assign abort = (state == ACCESS) & ~PREADY & (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ERR2: begin
        if (take) state_nxt = HWRITE ? WDATA : SETUP;
        else      state_nxt = IDLE;
      end
      WDATA:  state_nxt = SETUP;
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (done)       state_nxt = PSLVERR ? ERR1 : IDLE;
        else if (abort) state_nxt = ERR1;
      end
      ERR1:    state_nxt = ERR2;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b0;
    HRESP     = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state)
      IDLE:   HREADYOUT = 1'b1;
      SETUP:  PSEL = 1'b1;
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
      end
      ERR1:   HRESP = 1'b1;
      ERR2: begin
        HRESP     = 1'b1;
        HREADYOUT = 1'b1;
      end
      default: ;
    endcase
  end

  // Address/direction captured only on acceptance so they hold through ACCESS and while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PADDR  <= '0;
      PWRITE <= 1'b0;
      PWDATA <= '0;
      HRDATA <= '0;
    end else begin
      if (take) begin
        PADDR  <= HADDR;
        PWRITE <= HWRITE;
      end
      if (state == WDATA) PWDATA <= HWDATA;
      if (done && !PWRITE) HRDATA <= PRDATA;
    end
  end

endmodule
